// File: rtl/audio_frame_scheduler.sv
// audio_frame_scheduler: builds a mono stream from the L/R capture strobes, packs it into ping-pong frames and streams each frame out.
// Optional FRAME_PEAK_EN adds frame_peak, the largest |sample| of each delivered frame.
module audio_frame_scheduler #(
  parameter int DATA_W    = 24,
  parameter int FRAME_LEN = 256,
  parameter int ADDR_W    = 8
) (
  input  logic              cmn_clk,
  input  logic              cmn_rst_n,
  input  logic              enable,
  input  logic [1:0]        ch_mode,
  input  logic              tvalid_LC_audio,
  input  logic [DATA_W-1:0] LC_audio,
  input  logic              tvalid_RC_audio,
  input  logic [DATA_W-1:0] RC_audio,
  output logic              m_tvalid,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tlast,
  input  logic              m_tready,
  output logic [15:0]       frame_cnt,
  output logic              overflow,
  output logic              busy
`ifdef FRAME_PEAK_EN
  ,
  output logic [DATA_W-1:0] frame_peak
`endif
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_LEN - 1);
  typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;
  state_t state_q, state_d;
  logic [2:0] l_sync_q, l_sync_d, r_sync_q, r_sync_d;
  logic l_ev_q, l_ev_d, r_ev_q, r_ev_d;
  logic [DATA_W-1:0] l_data_q, l_data_d, r_data_q, r_data_d, l_hold_q, l_hold_d;
  logic held_q, held_d;
  logic wr_buf_q, wr_buf_d, rd_buf_q, rd_buf_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0] full_q, full_d;
  logic m_tvalid_q, m_tvalid_d, m_tlast_q, m_tlast_d;
  logic [DATA_W-1:0] m_tdata_q, m_tdata_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic overflow_q, overflow_d;
  logic avg_mode, r_mode, l_mode, held_eff, smp_v, wr_en, wr_last, last_hs;
  logic [DATA_W-1:0] l_val, smp;
  logic signed [DATA_W:0] sum;
  logic [DATA_W-1:0] mem [2*FRAME_LEN];
  always_comb begin
    l_sync_d = {l_sync_q[1:0], tvalid_LC_audio};
    r_sync_d = {r_sync_q[1:0], tvalid_RC_audio};
    l_ev_d   = l_sync_q[1] & ~l_sync_q[2];
    r_ev_d   = r_sync_q[1] & ~r_sync_q[2];
    l_data_d = l_ev_d ? LC_audio : l_data_q;
    r_data_d = r_ev_d ? RC_audio : r_data_q;
    avg_mode = ch_mode == 2'b10;
    r_mode   = ch_mode == 2'b01;
    l_mode   = ~avg_mode & ~r_mode;
    // a left edge in the same cycle as a right edge is consumed first
    held_eff = held_q | l_ev_q;
    l_val    = l_ev_q ? l_data_q : l_hold_q;
    sum      = $signed({l_val[DATA_W-1], l_val}) + $signed({r_data_q[DATA_W-1], r_data_q});
    smp_v    = enable & ((l_mode & l_ev_q) | (r_mode & r_ev_q) | (avg_mode & r_ev_q & held_eff));
    smp      = avg_mode ? DATA_W'(sum >>> 1) : r_mode ? r_data_q : l_data_q;
    l_hold_d = (enable & avg_mode & l_ev_q) ? l_data_q : l_hold_q;
    held_d   = enable & (avg_mode ? held_eff & ~r_ev_q : held_q);
    wr_en      = smp_v & ~full_q[wr_buf_q];
    wr_last    = wr_en & (wr_ptr_q == LAST);
    overflow_d = overflow_q | (smp_v & full_q[wr_buf_q]);
    wr_ptr_d   = wr_en ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    wr_buf_d   = wr_buf_q ^ wr_last;
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    rd_buf_d    = rd_buf_q;
    m_tvalid_d  = m_tvalid_q;
    m_tlast_d   = m_tlast_q;
    m_tdata_d   = m_tdata_q;
    frame_cnt_d = frame_cnt_q;
    last_hs     = (state_q == STREAM) & m_tready & m_tlast_q;
    case (state_q)
      IDLE: if (full_q[rd_buf_q]) begin
        state_d  = LOAD;
        rd_ptr_d = '0;
      end
      LOAD: begin
        m_tdata_d  = mem[{rd_buf_q, rd_ptr_q}];
        m_tlast_d  = rd_ptr_q == LAST;
        m_tvalid_d = 1'b1;
        state_d    = STREAM;
      end
      default: if (m_tready) begin
        m_tvalid_d = 1'b0;
        m_tlast_d  = 1'b0;
        if (m_tlast_q) begin
          rd_buf_d    = ~rd_buf_q;
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = IDLE;
        end else begin
          rd_ptr_d = rd_ptr_q + ADDR_W'(1);
          state_d  = LOAD;
        end
      end
    endcase
    // the reader only frees a full buffer and the writer only fills a non-full one, so both may apply
    full_d = full_q;
    if (last_hs) full_d[rd_buf_q] = 1'b0;
    if (wr_last) full_d[wr_buf_q] = 1'b1;
  end
  always_ff @(posedge cmn_clk)
    if (wr_en) mem[{wr_buf_q, wr_ptr_q}] <= smp;
  always_ff @(posedge cmn_clk or negedge cmn_rst_n)
    if (!cmn_rst_n) begin
      state_q     <= IDLE;
      l_sync_q    <= '0;
      r_sync_q    <= '0;
      l_ev_q      <= 1'b0;
      r_ev_q      <= 1'b0;
      l_data_q    <= '0;
      r_data_q    <= '0;
      l_hold_q    <= '0;
      held_q      <= 1'b0;
      wr_buf_q    <= 1'b0;
      rd_buf_q    <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      full_q      <= '0;
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
      m_tdata_q   <= '0;
      frame_cnt_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      l_sync_q    <= l_sync_d;
      r_sync_q    <= r_sync_d;
      l_ev_q      <= l_ev_d;
      r_ev_q      <= r_ev_d;
      l_data_q    <= l_data_d;
      r_data_q    <= r_data_d;
      l_hold_q    <= l_hold_d;
      held_q      <= held_d;
      wr_buf_q    <= wr_buf_d;
      rd_buf_q    <= rd_buf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      full_q      <= full_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tlast_q   <= m_tlast_d;
      m_tdata_q   <= m_tdata_d;
      frame_cnt_q <= frame_cnt_d;
      overflow_q  <= overflow_d;
    end
  assign m_tvalid  = m_tvalid_q;
  assign m_tdata   = m_tdata_q;
  assign m_tlast   = m_tlast_q;
  assign frame_cnt = frame_cnt_q;
  assign overflow  = overflow_q;
  assign busy      = |full_q | (state_q != IDLE) | (wr_ptr_q != '0);
`ifdef FRAME_PEAK_EN
  localparam logic [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  logic [DATA_W-1:0] peak_q [2], peak_d [2];
  logic [DATA_W-1:0] frame_peak_q, frame_peak_d, smp_abs;
  always_comb begin
    smp_abs = ~smp[DATA_W-1] ? smp : (smp == S_MIN) ? S_MAX : -smp;
    peak_d  = peak_q;
    if (wr_en && (wr_ptr_q == '0 || smp_abs > peak_q[wr_buf_q])) peak_d[wr_buf_q] = smp_abs;
    frame_peak_d = last_hs ? peak_q[rd_buf_q] : frame_peak_q;
  end
  always_ff @(posedge cmn_clk or negedge cmn_rst_n)
    if (!cmn_rst_n) begin
      peak_q       <= '{default: '0};
      frame_peak_q <= '0;
    end else begin
      peak_q       <= peak_d;
      frame_peak_q <= frame_peak_d;
    end
  assign frame_peak = frame_peak_q;
`endif
endmodule

// File: tb/tb_audio_frame_scheduler.sv
// tb_audio_frame_scheduler: directed scoreboard bench for audio_frame_scheduler with FRAME_LEN=4.
module tb_audio_frame_scheduler;
  localparam int DW = 24, FL = 4, AW = 2;
  logic cmn_clk = 1'b0, cmn_rst_n = 1'b0, enable = 1'b0, m_tready = 1'b0;
  logic [1:0] ch_mode = 2'b00;
  logic tvalid_LC_audio = 1'b0, tvalid_RC_audio = 1'b0;
  logic [DW-1:0] LC_audio = '0, RC_audio = '0;
  logic m_tvalid, m_tlast, overflow, busy;
  logic [DW-1:0] m_tdata;
  logic [15:0] frame_cnt;
`ifdef FRAME_PEAK_EN
  logic [DW-1:0] frame_peak;
`endif
  typedef struct packed {logic [DW-1:0] d; logic l;} exp_t;
  exp_t exp_q[$];
  exp_t e;
  int pos = 0, checks = 0, errors = 0;
  logic prev_stall = 1'b0, prev_l = 1'b0;
  logic [DW-1:0] prev_d = '0;
  audio_frame_scheduler #(.DATA_W(DW), .FRAME_LEN(FL), .ADDR_W(AW)) dut (
    .cmn_clk(cmn_clk), .cmn_rst_n(cmn_rst_n), .enable(enable), .ch_mode(ch_mode),
    .tvalid_LC_audio(tvalid_LC_audio), .LC_audio(LC_audio),
    .tvalid_RC_audio(tvalid_RC_audio), .RC_audio(RC_audio),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tready(m_tready),
    .frame_cnt(frame_cnt), .overflow(overflow), .busy(busy)
`ifdef FRAME_PEAK_EN
    , .frame_peak(frame_peak)
`endif
  );
  always #5 cmn_clk = ~cmn_clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask
  task automatic push(input logic [DW-1:0] d);
    exp_q.push_back('{d: d, l: (pos == FL - 1)});
    pos = (pos + 1) % FL;
  endtask
  function automatic logic [DW-1:0] avg(input logic [DW-1:0] l, input logic [DW-1:0] r);
    int s;
    s = int'($signed(l)) + int'($signed(r));
    return DW'(s >>> 1);
  endfunction
  task automatic send_l(input logic [DW-1:0] d, input bit exp_word);
    @(posedge cmn_clk); #1;
    LC_audio = d;
    tvalid_LC_audio = 1'b1;
    if (exp_word) push(d);
    repeat (3) @(posedge cmn_clk);
    #1 tvalid_LC_audio = 1'b0;
    repeat (4) @(posedge cmn_clk);
  endtask
  task automatic send_r(input logic [DW-1:0] d);
    @(posedge cmn_clk); #1;
    RC_audio = d;
    tvalid_RC_audio = 1'b1;
    repeat (3) @(posedge cmn_clk);
    #1 tvalid_RC_audio = 1'b0;
    repeat (4) @(posedge cmn_clk);
  endtask
  task automatic send_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
    send_l(l, 1'b0);
    send_r(r);
    push(avg(l, r));
  endtask
  task automatic drain(input string tag);
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(posedge cmn_clk);
    check(tag, 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge cmn_clk);
  endtask
  always @(negedge cmn_clk) begin
    if (prev_stall && m_tvalid) begin
      check("stall_data", 32'(m_tdata), 32'(prev_d));
      check("stall_last", 32'(m_tlast), 32'(prev_l));
    end
    if (m_tvalid && m_tready) begin
      check("word_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("m_tdata", 32'(m_tdata), 32'(e.d));
        check("m_tlast", 32'(m_tlast), 32'(e.l));
      end
    end
    prev_stall = m_tvalid && !m_tready;
    prev_d = m_tdata;
    prev_l = m_tlast;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    #22;
    check("rst_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_tdata", 32'(m_tdata), 32'd0);
    check("rst_tlast", 32'(m_tlast), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge cmn_clk) cmn_rst_n = 1'b1;
    @(posedge cmn_clk); #1;
    enable = 1'b1;
    m_tready = 1'b1;
    ch_mode = 2'b00;
    for (int i = 1; i <= 4; i++) send_l(DW'(i), 1'b1);
    drain("drain_left");
    check("frame_cnt_1", 32'(frame_cnt), 32'd1);
    check("busy_idle_1", 32'(busy), 32'd0);
    ch_mode = 2'b10;
    for (int i = 0; i < 4; i++) send_pair(24'h000010, 24'h000020);
    send_pair(24'hFFFFFE, 24'hFFFFFC);
    send_pair(24'h000007, 24'hFFFFF8);
    send_pair(24'h000003, 24'h000004);
    send_pair(24'h7FFFFF, 24'h7FFFFF);
    drain("drain_avg");
    check("frame_cnt_3", 32'(frame_cnt), 32'd3);
    send_r(24'h000123);
    repeat (4) @(negedge cmn_clk);
    check("orphan_right_busy", 32'(busy), 32'd0);
    send_l(24'h000044, 1'b0);
    @(posedge cmn_clk); #1 enable = 1'b0;
    repeat (3) @(posedge cmn_clk);
    #1 enable = 1'b1;
    send_r(24'h000066);
    repeat (4) @(negedge cmn_clk);
    check("held_cleared_busy", 32'(busy), 32'd0);
    ch_mode = 2'b11;
    enable = 1'b0;
    send_l(24'h000055, 1'b0);
    repeat (4) @(negedge cmn_clk);
    check("disabled_busy", 32'(busy), 32'd0);
    enable = 1'b1;
    m_tready = 1'b0;
    for (int i = 0; i < 12; i++) send_l(DW'(32'h100 + i), i < 8);
    @(negedge cmn_clk);
    check("overflow_set", 32'(overflow), 32'd1);
    check("stalled_tvalid", 32'(m_tvalid), 32'd1);
    check("stalled_frame_cnt", 32'(frame_cnt), 32'd3);
    @(posedge cmn_clk); #1 m_tready = 1'b1;
    drain("drain_overflow");
    check("frame_cnt_5", 32'(frame_cnt), 32'd5);
    check("overflow_sticky", 32'(overflow), 32'd1);
    m_tready = 1'b0;
    ch_mode = 2'b01;
    for (int i = 0; i < 4; i++) send_r(DW'(32'hA00 + i * 3));
    for (int i = 0; i < 4; i++) push(DW'(32'hA00 + i * 3));
    for (int i = 0; i < 40; i++) begin
      @(posedge cmn_clk); #1 m_tready = ~m_tready;
    end
    m_tready = 1'b1;
    drain("drain_toggle");
    check("frame_cnt_6", 32'(frame_cnt), 32'd6);
    m_tready = 1'b0;
    ch_mode = 2'b00;
    for (int i = 0; i < 6; i++) send_l(DW'(32'h300 + i), 1'b0);
    @(posedge cmn_clk); #3 cmn_rst_n = 1'b0;
    #1;
    check("async_rst_tvalid", 32'(m_tvalid), 32'd0);
    check("async_rst_tdata", 32'(m_tdata), 32'd0);
    check("async_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("async_rst_overflow", 32'(overflow), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    pos = 0;
    @(negedge cmn_clk) cmn_rst_n = 1'b1;
    m_tready = 1'b1;
    for (int i = 0; i < 4; i++) send_l(DW'(32'h7000 + i), 1'b1);
    drain("drain_after_rst");
    check("frame_cnt_after_rst", 32'(frame_cnt), 32'd1);
    check("busy_after_rst", 32'(busy), 32'd0);
`ifdef FRAME_PEAK_EN
    send_l(24'h000005, 1'b1);
    send_l(24'hFFFFF7, 1'b1);
    send_l(24'h000003, 1'b1);
    send_l(24'h000000, 1'b1);
    drain("drain_peak");
    check("frame_peak_9", 32'(frame_peak), 32'd9);
    send_l(24'h800000, 1'b1);
    send_l(24'h000001, 1'b1);
    send_l(24'h000002, 1'b1);
    send_l(24'h000003, 1'b1);
    drain("drain_peak_min");
    check("frame_peak_sat", 32'(frame_peak), 32'h7FFFFF);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
